// File: rtl/z80fi_insn_recorder_pkg.sv
// Shared types and constants for the Z80FI instruction recorder: FSM encoding,
// default record length and the packed register-file snapshot layout.
package z80fi_insn_recorder_pkg;

    localparam int MAX_LEN_DEF = 4;
    localparam int REGS_W      = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    // Field order is the register index list shared with the spec checkers
    typedef struct packed {
        logic [15:0] ip;
        logic [7:0]  f;
        logic [7:0]  a;
        logic [15:0] bc;
        logic [15:0] de;
        logic [15:0] hl;
        logic [15:0] ix;
        logic [15:0] iy;
        logic [15:0] sp;
    } z80_regs_t;

    // Byte count after an optional append, never exceeding the lane count
    function automatic logic [2:0] count_after(input logic [2:0] cnt,
                                               input logic       add,
                                               input logic [2:0] max_len);
        logic [2:0] res;
        if (add && (cnt < max_len)) begin
            res = cnt + 3'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/z80fi_insn_recorder_snapshot.sv
// Register-file snapshot: latches the packed register set on a capture strobe
// and holds it until the next strobe.
module z80fi_insn_recorder_snapshot
    import z80fi_insn_recorder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [REGS_W-1:0] d,
    output logic [REGS_W-1:0] q
);

    logic [REGS_W-1:0] snap_r;

    // Capture register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r <= {REGS_W{1'b0}};
        end else if (capture) begin
            snap_r <= d;
        end else begin
            snap_r <= snap_r;
        end
    end

    assign q = snap_r;

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Z80FI trace producer: gathers instruction bytes between insn_start and
// insn_done, snapshots registers at both ends and emits a one-cycle record.
module z80fi_insn_recorder
    import z80fi_insn_recorder_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 insn_start,
    input  logic                 fetch_valid,
    input  logic [7:0]           fetch_byte,
    input  logic                 insn_done,
    input  logic [15:0]          reg_ip_cur,
    input  logic [7:0]           reg_f_cur,
    input  logic [7:0]           reg_a_cur,
    input  logic [15:0]          reg_bc_cur,
    input  logic [15:0]          reg_de_cur,
    input  logic [15:0]          reg_hl_cur,
    input  logic [15:0]          reg_ix_cur,
    input  logic [15:0]          reg_iy_cur,
    input  logic [15:0]          reg_sp_cur,
    output logic                 z80fi_valid,
    output logic [8*MAX_LEN-1:0] z80fi_insn,
    output logic [2:0]           z80fi_insn_len,
    output logic [15:0]          z80fi_reg_ip_in,
    output logic [7:0]           z80fi_reg_f_in,
    output logic [7:0]           z80fi_reg_a_in,
    output logic [15:0]          z80fi_reg_bc_in,
    output logic [15:0]          z80fi_reg_de_in,
    output logic [15:0]          z80fi_reg_hl_in,
    output logic [15:0]          z80fi_reg_ix_in,
    output logic [15:0]          z80fi_reg_iy_in,
    output logic [15:0]          z80fi_reg_sp_in,
    output logic [15:0]          z80fi_reg_ip_out,
    output logic [7:0]           z80fi_reg_f_out,
    output logic [7:0]           z80fi_reg_a_out,
    output logic [15:0]          z80fi_reg_bc_out,
    output logic [15:0]          z80fi_reg_de_out,
    output logic [15:0]          z80fi_reg_hl_out,
    output logic [15:0]          z80fi_reg_ix_out,
    output logic [15:0]          z80fi_reg_iy_out,
    output logic [15:0]          z80fi_reg_sp_out,
    output logic                 z80fi_overflow
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_LEN);

    state_e               state_r;
    logic                 act_r;
    logic [2:0]           cnt_r;
    logic [8*MAX_LEN-1:0] buf_r;
    logic                 valid_r;
    logic [8*MAX_LEN-1:0] insn_r;
    logic [2:0]           len_r;
    logic                 overflow_r;

    logic                 collecting_s;
    logic                 add_s;
    logic                 room_s;
    logic                 done_ok_s;
    logic [8*MAX_LEN-1:0] rec_bytes_s;
    logic [2:0]           rec_len_s;
    z80_regs_t            cur_s;
    logic [REGS_W-1:0]    in_hold_s;
    logic [REGS_W-1:0]    in_pub_s;
    logic [REGS_W-1:0]    out_pub_s;
    z80_regs_t            in_regs_s;
    z80_regs_t            out_regs_s;

    assign cur_s = '{ip: reg_ip_cur, f: reg_f_cur, a: reg_a_cur,
                     bc: reg_bc_cur, de: reg_de_cur, hl: reg_hl_cur,
                     ix: reg_ix_cur, iy: reg_iy_cur, sp: reg_sp_cur};

    // EMIT still collects when the next instruction began in the done cycle
    assign collecting_s = (state_r == ST_COLLECT) || ((state_r == ST_EMIT) && act_r);
    // A byte fetched alongside insn_start belongs to the new instruction
    assign add_s        = collecting_s && fetch_valid && !insn_start;
    assign room_s       = (cnt_r < MAX_CNT);
    assign done_ok_s    = collecting_s && insn_done && ((cnt_r != 3'd0) || add_s);
    assign rec_len_s    = count_after(cnt_r, add_s, MAX_CNT);

    // Byte-lane write decoder: merge the current byte into lane cnt_r
    always_comb begin
        rec_bytes_s = buf_r;
        if (add_s && room_s) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (3'(i) == cnt_r) begin
                    rec_bytes_s[8*i +: 8] = fetch_byte;
                end else begin
                    rec_bytes_s[8*i +: 8] = buf_r[8*i +: 8];
                end
            end
        end else begin
            rec_bytes_s = buf_r;
        end
    end

    // Recorder FSM, byte buffer, counter, record outputs and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            act_r      <= 1'b0;
            cnt_r      <= 3'd0;
            buf_r      <= {(8*MAX_LEN){1'b0}};
            valid_r    <= 1'b0;
            insn_r     <= {(8*MAX_LEN){1'b0}};
            len_r      <= 3'd0;
            overflow_r <= 1'b0;
        end else begin
            valid_r <= done_ok_s;
            if (done_ok_s) begin
                insn_r <= rec_bytes_s;
                len_r  <= rec_len_s;
            end else begin
                insn_r <= insn_r;
                len_r  <= len_r;
            end

            if (insn_start) begin
                buf_r <= {{(8*MAX_LEN-8){1'b0}}, (fetch_valid ? fetch_byte : 8'h00)};
                cnt_r <= fetch_valid ? 3'd1 : 3'd0;
                act_r <= 1'b1;
            end else begin
                buf_r <= rec_bytes_s;
                cnt_r <= rec_len_s;
                act_r <= act_r && !done_ok_s;
            end

            if (add_s && !room_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            case (state_r)
                ST_IDLE: begin
                    state_r <= insn_start ? ST_COLLECT : ST_IDLE;
                end
                ST_COLLECT: begin
                    state_r <= done_ok_s ? ST_EMIT : ST_COLLECT;
                end
                ST_EMIT: begin
                    if (done_ok_s) begin
                        state_r <= ST_EMIT;
                    end else if (insn_start || act_r) begin
                        state_r <= ST_COLLECT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // in_hold tracks the live instruction; in_pub/out_pub hold the published record
    z80fi_insn_recorder_snapshot u_in_hold (
        .clk(clk), .reset(reset), .capture(insn_start), .d(cur_s), .q(in_hold_s)
    );
    z80fi_insn_recorder_snapshot u_in_pub (
        .clk(clk), .reset(reset), .capture(done_ok_s), .d(in_hold_s), .q(in_pub_s)
    );
    z80fi_insn_recorder_snapshot u_out_pub (
        .clk(clk), .reset(reset), .capture(done_ok_s), .d(cur_s), .q(out_pub_s)
    );

    assign in_regs_s  = z80_regs_t'(in_pub_s);
    assign out_regs_s = z80_regs_t'(out_pub_s);

    assign z80fi_valid      = valid_r;
    assign z80fi_insn       = insn_r;
    assign z80fi_insn_len   = len_r;
    assign z80fi_overflow   = overflow_r;
    assign z80fi_reg_ip_in  = in_regs_s.ip;
    assign z80fi_reg_f_in   = in_regs_s.f;
    assign z80fi_reg_a_in   = in_regs_s.a;
    assign z80fi_reg_bc_in  = in_regs_s.bc;
    assign z80fi_reg_de_in  = in_regs_s.de;
    assign z80fi_reg_hl_in  = in_regs_s.hl;
    assign z80fi_reg_ix_in  = in_regs_s.ix;
    assign z80fi_reg_iy_in  = in_regs_s.iy;
    assign z80fi_reg_sp_in  = in_regs_s.sp;
    assign z80fi_reg_ip_out = out_regs_s.ip;
    assign z80fi_reg_f_out  = out_regs_s.f;
    assign z80fi_reg_a_out  = out_regs_s.a;
    assign z80fi_reg_bc_out = out_regs_s.bc;
    assign z80fi_reg_de_out = out_regs_s.de;
    assign z80fi_reg_hl_out = out_regs_s.hl;
    assign z80fi_reg_ix_out = out_regs_s.ix;
    assign z80fi_reg_iy_out = out_regs_s.iy;
    assign z80fi_reg_sp_out = out_regs_s.sp;

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Directed bench for z80fi_insn_recorder: drives instruction sequences and
// checks each record against hand-computed bytes, lengths and snapshots.
module tb_z80fi_insn_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        insn_start, fetch_valid, insn_done;
    logic [7:0]  fetch_byte;
    logic [15:0] reg_ip_cur, reg_bc_cur, reg_de_cur, reg_hl_cur, reg_ix_cur, reg_iy_cur, reg_sp_cur;
    logic [7:0]  reg_f_cur, reg_a_cur;
    logic        z80fi_valid, z80fi_overflow;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] ip_in, bc_in, de_in, hl_in, ix_in, iy_in, sp_in;
    logic [7:0]  f_in, a_in, f_out, a_out;
    logic [15:0] ip_out, bc_out, de_out, hl_out, ix_out, iy_out, sp_out;

    int total = 0;
    int bad   = 0;

    z80fi_insn_recorder dut (
        .clk(clk), .reset(reset), .insn_start(insn_start), .fetch_valid(fetch_valid),
        .fetch_byte(fetch_byte), .insn_done(insn_done),
        .reg_ip_cur(reg_ip_cur), .reg_f_cur(reg_f_cur), .reg_a_cur(reg_a_cur),
        .reg_bc_cur(reg_bc_cur), .reg_de_cur(reg_de_cur), .reg_hl_cur(reg_hl_cur),
        .reg_ix_cur(reg_ix_cur), .reg_iy_cur(reg_iy_cur), .reg_sp_cur(reg_sp_cur),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(ip_in), .z80fi_reg_f_in(f_in), .z80fi_reg_a_in(a_in),
        .z80fi_reg_bc_in(bc_in), .z80fi_reg_de_in(de_in), .z80fi_reg_hl_in(hl_in),
        .z80fi_reg_ix_in(ix_in), .z80fi_reg_iy_in(iy_in), .z80fi_reg_sp_in(sp_in),
        .z80fi_reg_ip_out(ip_out), .z80fi_reg_f_out(f_out), .z80fi_reg_a_out(a_out),
        .z80fi_reg_bc_out(bc_out), .z80fi_reg_de_out(de_out), .z80fi_reg_hl_out(hl_out),
        .z80fi_reg_ix_out(ix_out), .z80fi_reg_iy_out(iy_out), .z80fi_reg_sp_out(sp_out),
        .z80fi_overflow(z80fi_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic s, input logic fv, input logic [7:0] b, input logic d);
        insn_start = s; fetch_valid = fv; fetch_byte = b; insn_done = d;
        @(posedge clk);
        #1;
        insn_start = 1'b0; fetch_valid = 1'b0; fetch_byte = 8'h00; insn_done = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] ip, input logic [15:0] ix, input logic [15:0] bc);
        reg_ip_cur = ip; reg_ix_cur = ix; reg_bc_cur = bc;
    endtask

    initial begin
        reset = 1'b1;
        insn_start = 1'b0; fetch_valid = 1'b0; fetch_byte = 8'h00; insn_done = 1'b0;
        reg_f_cur = 8'h44; reg_a_cur = 8'h5A; reg_de_cur = 16'h1111; reg_hl_cur = 16'h2222;
        reg_iy_cur = 16'h3333; reg_sp_cur = 16'hFFF0;
        set_regs(16'h0000, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_valid", {31'd0, z80fi_valid}, 32'd0);
        chk("rst_insn", z80fi_insn, 32'd0);
        chk("rst_len", {29'd0, z80fi_insn_len}, 32'd0);
        chk("rst_ovf", {31'd0, z80fi_overflow}, 32'd0);
        chk("rst_sp_out", {16'd0, sp_out}, 32'd0);
        reset = 1'b0;

        // ADD IX,BC
        set_regs(16'h0100, 16'h1000, 16'h0234);
        cyc(1'b1, 1'b1, 8'hDD, 1'b0);
        chk("add_nvalid", {31'd0, z80fi_valid}, 32'd0);
        set_regs(16'h0102, 16'h1234, 16'h0234);
        cyc(1'b0, 1'b1, 8'h09, 1'b1);
        chk("add_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("add_insn", z80fi_insn, 32'h000009DD);
        chk("add_len", {29'd0, z80fi_insn_len}, 32'd2);
        chk("add_ix_in", {16'd0, ix_in}, 32'h1000);
        chk("add_bc_in", {16'd0, bc_in}, 32'h0234);
        chk("add_ip_in", {16'd0, ip_in}, 32'h0100);
        chk("add_ix_out", {16'd0, ix_out}, 32'h1234);
        chk("add_ip_out", {16'd0, ip_out}, 32'h0102);
        chk("add_a_out", {24'd0, a_out}, 32'h5A);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("add_pulse", {31'd0, z80fi_valid}, 32'd0);
        chk("add_hold", z80fi_insn, 32'h000009DD);

        // LD IX,nn
        set_regs(16'h0200, 16'h1234, 16'h0234);
        cyc(1'b1, 1'b1, 8'hDD, 1'b0);
        cyc(1'b0, 1'b1, 8'h21, 1'b0);
        cyc(1'b0, 1'b1, 8'h34, 1'b0);
        chk("ld_nvalid", {31'd0, z80fi_valid}, 32'd0);
        set_regs(16'h0204, 16'h1234, 16'h0234);
        cyc(1'b0, 1'b1, 8'h12, 1'b1);
        chk("ld_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("ld_insn", z80fi_insn, 32'h123421DD);
        chk("ld_len", {29'd0, z80fi_insn_len}, 32'd4);
        chk("ld_ovf", {31'd0, z80fi_overflow}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ld_pulse", {31'd0, z80fi_valid}, 32'd0);

        // Back-to-back NOPs
        set_regs(16'h0300, 16'h1234, 16'h0234);
        cyc(1'b1, 1'b1, 8'h00, 1'b0);
        set_regs(16'h0301, 16'h1234, 16'h0234);
        cyc(1'b1, 1'b1, 8'h00, 1'b1);
        chk("nop1_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("nop1_len", {29'd0, z80fi_insn_len}, 32'd1);
        chk("nop1_insn", z80fi_insn, 32'd0);
        chk("nop1_ip_in", {16'd0, ip_in}, 32'h0300);
        chk("nop1_ip_out", {16'd0, ip_out}, 32'h0301);
        set_regs(16'h0302, 16'h1234, 16'h0234);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("nop2_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("nop2_len", {29'd0, z80fi_insn_len}, 32'd1);
        chk("nop2_ip_in", {16'd0, ip_in}, 32'h0301);
        chk("nop2_ip_out", {16'd0, ip_out}, 32'h0302);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("nop_pulse", {31'd0, z80fi_valid}, 32'd0);

        // Restart without done
        set_regs(16'h0400, 16'h1234, 16'h0234);
        cyc(1'b1, 1'b1, 8'hDD, 1'b0);
        set_regs(16'h0410, 16'h4321, 16'h0234);
        cyc(1'b1, 1'b1, 8'hFD, 1'b0);
        chk("rs_nvalid", {31'd0, z80fi_valid}, 32'd0);
        set_regs(16'h0412, 16'h4321, 16'h0234);
        cyc(1'b0, 1'b1, 8'h23, 1'b1);
        chk("rs_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("rs_insn", z80fi_insn, 32'h000023FD);
        chk("rs_len", {29'd0, z80fi_insn_len}, 32'd2);
        chk("rs_ip_in", {16'd0, ip_in}, 32'h0410);
        chk("rs_ix_in", {16'd0, ix_in}, 32'h4321);

        // Five bytes: overflow
        set_regs(16'h0500, 16'h4321, 16'h0234);
        cyc(1'b1, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b0);
        cyc(1'b0, 1'b1, 8'h44, 1'b0);
        chk("ov_pre", {31'd0, z80fi_overflow}, 32'd0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        chk("ov_set", {31'd0, z80fi_overflow}, 32'd1);
        chk("ov_nvalid", {31'd0, z80fi_valid}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ov_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("ov_insn", z80fi_insn, 32'h44332211);
        chk("ov_len", {29'd0, z80fi_insn_len}, 32'd4);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ov_sticky", {31'd0, z80fi_overflow}, 32'd1);

        // Done in IDLE, fetch in IDLE, done with zero bytes
        cyc(1'b0, 1'b1, 8'h77, 1'b1);
        chk("idle_done", {31'd0, z80fi_valid}, 32'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("zero_done", {31'd0, z80fi_valid}, 32'd0);
        chk("zero_hold", z80fi_insn, 32'h44332211);

        // Reset mid-instruction
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        cyc(1'b0, 1'b1, 8'hBB, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'hCC, 1'b1);
        reset = 1'b0;
        chk("mr_valid", {31'd0, z80fi_valid}, 32'd0);
        chk("mr_insn", z80fi_insn, 32'd0);
        chk("mr_len", {29'd0, z80fi_insn_len}, 32'd0);
        chk("mr_ovf", {31'd0, z80fi_overflow}, 32'd0);
        chk("mr_ix_in", {16'd0, ix_in}, 32'd0);
        chk("mr_ip_out", {16'd0, ip_out}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mr_after", {31'd0, z80fi_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
